// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: per-slot one-shot or periodic alarms matched on
// equality against cur_time, delivered one at a time through a valid/ready stage.
module alarm_scheduler #(
  parameter  int N_SLOTS = 4,
  parameter  int TW      = 16,
  localparam int IW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TW-1:0]      cur_time,
  input  logic               cfg_en,
  input  logic [IW-1:0]      cfg_idx,
  input  logic               cfg_arm,
  input  logic [TW-1:0]      cfg_time,
  input  logic [TW-1:0]      cfg_period,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IW-1:0]      evt_idx,
  output logic [TW-1:0]      evt_time,
  output logic [N_SLOTS-1:0] armed,
  output logic [N_SLOTS-1:0] missed
);

  logic [N_SLOTS-1:0] armed_q, armed_d;
  logic [N_SLOTS-1:0] pending_q, pending_d;
  logic [N_SLOTS-1:0] missed_q, missed_d;
  logic [TW-1:0]      target_q [N_SLOTS];
  logic [TW-1:0]      target_d [N_SLOTS];
  logic [TW-1:0]      period_q [N_SLOTS];
  logic [TW-1:0]      period_d [N_SLOTS];
  logic [TW-1:0]      pend_time_q [N_SLOTS];
  logic [TW-1:0]      pend_time_d [N_SLOTS];

  logic               evt_valid_q, evt_valid_d;
  logic [IW-1:0]      evt_idx_q, evt_idx_d;
  logic [TW-1:0]      evt_time_q, evt_time_d;

  logic [N_SLOTS-1:0] match;
  logic               load;
  logic               found;
  logic [IW-1:0]      sel;

  // A match acts on the same edge it is seen, so a one-shot is disarmed before
  // cur_time can match it a second time.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_match
      assign match[gi] = armed_q[gi] && (cur_time == target_q[gi]);
    end
  endgenerate

  always_comb begin
    armed_d     = armed_q;
    pending_d   = pending_q;
    missed_d    = missed_q;
    target_d    = target_q;
    period_d    = period_q;
    pend_time_d = pend_time_q;
    evt_valid_d = evt_valid_q;
    evt_idx_d   = evt_idx_q;
    evt_time_d  = evt_time_q;
    found       = 1'b0;
    sel         = '0;

    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end

    load = !evt_valid_q || evt_ready;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_idx_d  = sel;
        evt_time_d = pend_time_q[sel];
      end
    end

    for (int i = 0; i < N_SLOTS; i++) begin
      if (load && found && (sel == IW'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (cfg_en && (cfg_idx == IW'(i))) begin
        // Configuration wins over a same-cycle match on this slot.
        if (cfg_arm) begin
          armed_d[i]  = 1'b1;
          target_d[i] = cfg_time;
          period_d[i] = cfg_period;
        end else begin
          armed_d[i]   = 1'b0;
          pending_d[i] = 1'b0;
          missed_d[i]  = 1'b0;
        end
      end else if (match[i]) begin
        if (pending_d[i]) begin
          missed_d[i] = 1'b1;
        end else begin
          pending_d[i]   = 1'b1;
          pend_time_d[i] = target_q[i];
        end
        if (period_q[i] != '0) begin
          target_d[i] = target_q[i] + period_q[i];
        end else begin
          armed_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= '0;
      pending_q   <= '0;
      missed_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      evt_time_q  <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        target_q[i]    <= '0;
        period_q[i]    <= '0;
        pend_time_q[i] <= '0;
      end
    end else begin
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      evt_time_q  <= evt_time_d;
      for (int i = 0; i < N_SLOTS; i++) begin
        target_q[i]    <= target_d[i];
        period_q[i]    <= period_d[i];
        pend_time_q[i] <= pend_time_d[i];
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign evt_time  = evt_time_q;
  assign armed     = armed_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: inputs driven and outputs sampled on the
// falling clock edge.
module tb_alarm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cur_time;
  logic        cfg_en;
  logic [1:0]  cfg_idx;
  logic        cfg_arm;
  logic [15:0] cfg_time;
  logic [15:0] cfg_period;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_idx;
  logic [15:0] evt_time;
  logic [3:0]  armed;
  logic [3:0]  missed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(.N_SLOTS(4), .TW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cur_time(cur_time),
    .cfg_en(cfg_en), .cfg_idx(cfg_idx), .cfg_arm(cfg_arm),
    .cfg_time(cfg_time), .cfg_period(cfg_period),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_time(evt_time), .armed(armed), .missed(missed)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic arm,
                           input logic [15:0] t, input logic [15:0] p);
    cfg_en = 1'b1; cfg_idx = idx; cfg_arm = arm; cfg_time = t; cfg_period = p;
    step();
    cfg_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cur_time = '0; cfg_en = 1'b0; cfg_idx = '0; cfg_arm = 1'b0;
    cfg_time = '0; cfg_period = '0; evt_ready = 1'b1;
    #12;
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_checks++;
    if ({evt_idx, evt_time} !== 18'h0) begin n_fail++; $display("FAIL reset_evt: got idx %h time %h expected 0/0", evt_idx, evt_time); end
    n_checks++;
    if ({armed, missed} !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got armed %b missed %b expected 0/0", armed, missed); end
    step();
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_one_shot();
    int cnt = 0;
    cfg_write(2'd1, 1'b1, 16'h0010, 16'h0000);
    n_checks++;
    if (armed !== 4'b0010) begin n_fail++; $display("FAIL oneshot_armed: got %b expected 0010", armed); end
    for (int i = 0; i < 14; i++) begin
      cur_time = (i < 4) ? 16'(16'h000C + i) : ((i < 10) ? 16'h0010 : 16'h0011);
      step();
      if (evt_valid) begin
        cnt++;
        n_checks++;
        if (evt_idx !== 2'd1 || evt_time !== 16'h0010) begin
          n_fail++; $display("FAIL oneshot_evt: got idx %0d time %h expected 1/0010", evt_idx, evt_time);
        end
      end
    end
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL oneshot_count: got %0d expected 1", cnt); end
    n_checks++;
    if (armed[1] !== 1'b0) begin n_fail++; $display("FAIL oneshot_disarm: got %b expected 0", armed[1]); end
    $display("test_one_shot done: %0d events", cnt);
  endtask

  task automatic test_periodic_wrap();
    logic [15:0] stim [10] = '{16'hFFF0, 16'h0001, 16'h0001, 16'h0010, 16'h0001,
                               16'h0001, 16'h0030, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] expt [3] = '{16'hFFF0, 16'h0010, 16'h0030};
    logic [15:0] got [3];
    int cnt = 0;
    cfg_write(2'd0, 1'b1, 16'hFFF0, 16'h0020);
    for (int i = 0; i < 12; i++) begin
      cur_time = (i < 10) ? stim[i] : 16'h0001;
      step();
      if (evt_valid) begin
        if (cnt < 3) got[cnt] = evt_time;
        n_checks++;
        if (evt_idx !== 2'd0) begin n_fail++; $display("FAIL periodic_idx: got %0d expected 0", evt_idx); end
        cnt++;
      end
    end
    n_checks++;
    if (cnt != 3) begin n_fail++; $display("FAIL periodic_count: got %0d expected 3", cnt); end
    for (int k = 0; k < 3; k++) begin
      if (k < cnt) begin
        n_checks++;
        if (got[k] !== expt[k]) begin n_fail++; $display("FAIL periodic_time%0d: got %h expected %h", k, got[k], expt[k]); end
      end
    end
    n_checks++;
    if (armed[0] !== 1'b1) begin n_fail++; $display("FAIL periodic_armed: got %b expected 1", armed[0]); end
    cfg_write(2'd0, 1'b0, 16'h0000, 16'h0000);
    $display("test_periodic_wrap done: %0d events", cnt);
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b0;
    cfg_write(2'd2, 1'b1, 16'h0040, 16'h0000);
    cfg_write(2'd3, 1'b1, 16'h0040, 16'h0000);
    cur_time = 16'h0040;
    step();
    cur_time = 16'h0041;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || evt_time !== 16'h0040) begin
        n_fail++; $display("FAIL b2b_hold%0d: got v%b idx %0d time %h expected v1 idx 2 time 0040", i, evt_valid, evt_idx, evt_time);
      end
      step();
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd3 || evt_time !== 16'h0040) begin
      n_fail++; $display("FAIL b2b_second: got v%b idx %0d time %h expected v1 idx 3 time 0040", evt_valid, evt_idx, evt_time);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd3) begin n_fail++; $display("FAIL b2b_second_hold: got v%b idx %0d expected v1 idx 3", evt_valid, evt_idx); end
    evt_ready = 1'b1;
    step();
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", evt_valid); end
    n_checks++;
    if (armed !== 4'b0000) begin n_fail++; $display("FAIL b2b_armed: got %b expected 0000", armed); end
    $display("test_back_to_back done");
  endtask

  task automatic test_miss();
    evt_ready = 1'b0;
    cfg_write(2'd0, 1'b1, 16'h0100, 16'h0004);
    for (int t = 0; t < 12; t++) begin
      cur_time = 16'(16'h0100 + t);
      step();
    end
    n_checks++;
    if (missed !== 4'b0001) begin n_fail++; $display("FAIL miss_flag: got %b expected 0001", missed); end
    n_checks++;
    if (evt_valid !== 1'b1 || evt_time !== 16'h0100) begin n_fail++; $display("FAIL miss_first: got v%b time %h expected v1 time 0100", evt_valid, evt_time); end
    cur_time = 16'h0000;
    evt_ready = 1'b1;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_time !== 16'h0104) begin n_fail++; $display("FAIL miss_older: got v%b time %h expected v1 time 0104", evt_valid, evt_time); end
    evt_ready = 1'b0;
    cfg_write(2'd0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if (missed !== 4'b0000 || armed !== 4'b0000) begin n_fail++; $display("FAIL miss_clear: got missed %b armed %b expected 0000/0000", missed, armed); end
    n_checks++;
    if (evt_valid !== 1'b1 || evt_time !== 16'h0104) begin n_fail++; $display("FAIL miss_inflight: got v%b time %h expected v1 time 0104", evt_valid, evt_time); end
    evt_ready = 1'b1;
    step();
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL miss_drain: got %b expected 0", evt_valid); end
    $display("test_miss done");
  endtask

  task automatic test_cfg_collision();
    evt_ready = 1'b1;
    cfg_write(2'd1, 1'b1, 16'h0200, 16'h0000);
    cur_time = 16'h0200;
    cfg_write(2'd1, 1'b1, 16'h0300, 16'h0000);
    cur_time = 16'h0201;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (evt_valid !== 1'b0 || armed[1] !== 1'b1) begin
        n_fail++; $display("FAIL collide_quiet%0d: got v%b armed1 %b expected v0 armed1 1", i, evt_valid, armed[1]);
      end
    end
    cur_time = 16'h0300;
    step();
    cur_time = 16'h0301;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd1 || evt_time !== 16'h0300) begin
      n_fail++; $display("FAIL collide_new: got v%b idx %0d time %h expected v1 idx 1 time 0300", evt_valid, evt_idx, evt_time);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b0 || armed[1] !== 1'b0) begin n_fail++; $display("FAIL collide_done: got v%b armed1 %b expected v0 armed1 0", evt_valid, armed[1]); end
    $display("test_cfg_collision done");
  endtask

  task automatic test_reset_midop();
    evt_ready = 1'b0;
    cfg_write(2'd2, 1'b1, 16'h0400, 16'h0000);
    cfg_write(2'd3, 1'b1, 16'h0400, 16'h0010);
    cur_time = 16'h0400;
    step();
    cur_time = 16'h0401;
    step();
    cur_time = 16'h0410;
    step();
    cur_time = 16'h0411;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd2 || missed !== 4'b1000) begin
      n_fail++; $display("FAIL midop_pre: got v%b idx %0d missed %b expected v1 idx 2 missed 1000", evt_valid, evt_idx, missed);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || armed !== 4'b0000 || missed !== 4'b0000) begin
      n_fail++; $display("FAIL midop_async: got v%b armed %b missed %b expected 0/0000/0000", evt_valid, armed, missed);
    end
    n_checks++;
    if (evt_idx !== 2'd0 || evt_time !== 16'h0000) begin n_fail++; $display("FAIL midop_evt: got idx %0d time %h expected 0/0000", evt_idx, evt_time); end
    step();
    rst_n = 1'b1;
    cur_time = 16'h0000;
    evt_ready = 1'b1;
    step();
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midop_discard: got %b expected 0", evt_valid); end
    cfg_write(2'd0, 1'b1, 16'h0005, 16'h0000);
    cur_time = 16'h0005;
    step();
    cur_time = 16'h0006;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 2'd0 || evt_time !== 16'h0005) begin
      n_fail++; $display("FAIL midop_resume: got v%b idx %0d time %h expected v1 idx 0 time 0005", evt_valid, evt_idx, evt_time);
    end
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_wrap();
    test_back_to_back();
    test_miss();
    test_cfg_collision();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
